// File: rtl/matmul_apb_sequencer.sv
// matmul_apb_sequencer: buffers host commands in a small FIFO, issues each one
// as an APB read or write to the matmul slave port, and returns one in-order
// response per completed (or timed-out) transfer.
module matmul_apb_sequencer #(
  parameter int  BUS_WIDTH  = 32,
  parameter int  ADDR_WIDTH = 16,
  parameter int  CMD_DEPTH  = 4,
  parameter int  TIMEOUT    = 255,
  localparam int STRB_W     = BUS_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [BUS_WIDTH-1:0]  cmd_wdata_i,
  input  logic [STRB_W-1:0]     cmd_strb_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_write_o,
  output logic [BUS_WIDTH-1:0]  rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [BUS_WIDTH-1:0]  pwdata_o,
  output logic [STRB_W-1:0]     pstrb_o,
  input  logic                  pready_i,
  input  logic                  pslverr_i,
  input  logic [BUS_WIDTH-1:0]  prdata_i,
  input  logic                  busy_i
);

  localparam int              PTR_W      = $clog2(CMD_DEPTH);
  localparam logic [PTR_W:0]  FULL_COUNT = (PTR_W + 1)'(CMD_DEPTH);
  // Value of the wait counter during the last ACCESS cycle allowed to stall.
  localparam logic [9:0]      WAIT_LAST  = 10'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [BUS_WIDTH-1:0]  wdata;
    logic [STRB_W-1:0]     strb;
  } entry_t;

  entry_t           fifo_mem [CMD_DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [1:0]       state;
  logic [9:0]       wait_cnt;

  logic full, empty, push, pop;
  logic rsp_take, access_done, access_abort, rsp_load;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  assign head  = fifo_mem[rd_ptr];

  // Ready is held low while reset is asserted so no command is taken then.
  assign cmd_ready_o = !full && !rst_i;
  assign push        = cmd_valid_i && cmd_ready_o;
  assign rsp_take    = rsp_valid_o && rsp_ready_i;

  // Launch only from IDLE, with a free (or freeing) response slot, and never
  // start a write while the accelerator is busy; a stalled write blocks all.
  assign pop = (state == ST_IDLE) && !empty && (!rsp_valid_o || rsp_take) &&
               (!head.write || !busy_i);

  assign access_done  = (state == ST_ACCESS) && pready_i;
  assign access_abort = (state == ST_ACCESS) && !pready_i && (wait_cnt == WAIT_LAST);
  assign rsp_load     = access_done || access_abort;

  // Decoded from state so an asynchronous reset drops them immediately.
  assign psel_o    = (state != ST_IDLE);
  assign penable_o = (state == ST_ACCESS);

  // Command storage written on push.
  // NOTE: the storage array has no reset; occupancy is tracked by count, so stale entries are never read.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= '{cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i};
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Transfer sequencing IDLE -> SETUP -> ACCESS, with the ACCESS wait counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) state <= ST_SETUP;
        end
        ST_SETUP: begin
          state    <= ST_ACCESS;
          wait_cnt <= '0;
        end
        ST_ACCESS: begin
          if (rsp_load) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // APB address/data registers: loaded at launch, held through IDLE afterwards.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pwrite_o <= 1'b0;
      paddr_o  <= '0;
      pwdata_o <= '0;
      pstrb_o  <= '0;
    end else if (pop) begin
      pwrite_o <= head.write;
      paddr_o  <= head.addr;
      pwdata_o <= head.wdata;
      pstrb_o  <= head.write ? head.strb : '0;
    end
  end

  // Single response slot: loaded when ACCESS ends, cleared when consumed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_o <= 1'b0;
      rsp_write_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else if (rsp_load) begin
      rsp_valid_o <= 1'b1;
      rsp_write_o <= pwrite_o;
      rsp_err_o   <= !pready_i || pslverr_i;
      rsp_rdata_o <= (pready_i && !pslverr_i && !pwrite_o) ? prdata_i : '0;
    end else if (rsp_take) begin
      rsp_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_matmul_apb_sequencer.sv
// Testbench for matmul_apb_sequencer: a command-level reference model feeds
// expected APB transfers and responses into queues; a monitor/slave process
// compares what the DUT actually presents.
module tb_matmul_apb_sequencer;

  localparam int BW    = 32;
  localparam int AW    = 16;
  localparam int SW    = BW / 8;
  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic          cmd_write_i = 1'b0;
  logic [AW-1:0] cmd_addr_i = '0;
  logic [BW-1:0] cmd_wdata_i = '0;
  logic [SW-1:0] cmd_strb_i = '0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b0;
  logic          rsp_write_o;
  logic [BW-1:0] rsp_rdata_o;
  logic          rsp_err_o;
  logic          psel_o, penable_o, pwrite_o;
  logic [AW-1:0] paddr_o;
  logic [BW-1:0] pwdata_o;
  logic [SW-1:0] pstrb_o;
  logic          pready_i = 1'b0;
  logic          pslverr_i = 1'b0;
  logic [BW-1:0] prdata_i = '0;
  logic          busy_i = 1'b0;

  always #5 clk_i = ~clk_i;

  matmul_apb_sequencer #(
    .BUS_WIDTH (BW),
    .ADDR_WIDTH(AW),
    .CMD_DEPTH (DEPTH),
    .TIMEOUT   (TMO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_strb_i(cmd_strb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_write_o(rsp_write_o),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
    .pready_i(pready_i), .pslverr_i(pslverr_i), .prdata_i(prdata_i),
    .busy_i(busy_i)
  );

  typedef struct { bit write; logic [AW-1:0] addr; logic [BW-1:0] wdata; logic [SW-1:0] strb; } cmd_t;
  typedef struct { bit write; logic [BW-1:0] rdata; bit err; } rsp_t;
  // Slave behaviour for one transfer: number of pready-low cycles, then error flag.
  typedef struct { int waits; bit err; } plan_t;

  cmd_t  exp_apb_q[$];
  rsp_t  exp_rsp_q[$];
  plan_t plan_q[$];
  logic [BW-1:0] ref_mem [logic [AW-1:0]];
  logic [BW-1:0] slv_mem [logic [AW-1:0]];

  int    n_checks = 0;
  int    n_fail   = 0;
  bit    rand_env = 1'b0;
  bit    prev_busy = 1'b0;
  bit    slv_active = 1'b0;
  int    slv_cnt = 0;
  plan_t slv_plan;
  cmd_t  env_apb;
  rsp_t  env_rsp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] merge(input logic [BW-1:0] old, input logic [BW-1:0] wd,
                                          input logic [SW-1:0] st);
    logic [BW-1:0] r;
    r = old;
    for (int b = 0; b < SW; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [BW-1:0] rd_ref(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  function automatic logic [BW-1:0] rd_slv(input logic [AW-1:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : '0;
  endfunction

  // Reference model: a command either succeeds (memory semantics) or fails
  // (slave error or timeout) with zero read data; results are queued in order.
  task automatic model(input cmd_t c, input plan_t p);
    rsp_t r;
    cmd_t a;
    bit   ok;
    ok      = (p.waits < TMO) && !p.err;
    r.write = c.write;
    r.err   = !ok;
    r.rdata = '0;
    if (ok && c.write)  ref_mem[c.addr] = merge(rd_ref(c.addr), c.wdata, c.strb);
    if (ok && !c.write) r.rdata = rd_ref(c.addr);
    a = c;
    if (!c.write) a.strb = '0;
    exp_apb_q.push_back(a);
    exp_rsp_q.push_back(r);
    plan_q.push_back(p);
  endtask

  // Called and returns at a falling edge.
  task automatic send_cmd(input cmd_t c, input plan_t p);
    int n;
    n = 0;
    model(c, p);
    cmd_valid_i = 1'b1;
    cmd_write_i = c.write;
    cmd_addr_i  = c.addr;
    cmd_wdata_i = c.wdata;
    cmd_strb_i  = c.strb;
    while (!cmd_ready_o && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    check("cmd_accept", cmd_ready_o, 1);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_rsp_q.size() != 0 || psel_o) && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    check("drain_rsp_left", exp_rsp_q.size(), 0);
    @(negedge clk_i);
  endtask

  // Monitor, scoreboard and APB slave; runs just after each falling edge.
  always @(negedge clk_i) begin
    #1;
    if (rst_i) begin
      slv_active = 1'b0;
      pready_i   = 1'b0;
      pslverr_i  = 1'b0;
    end else begin
      if (rand_env) rsp_ready_i = ($urandom_range(0, 9) < 7);

      if (rsp_valid_o && rsp_ready_i) begin
        if (exp_rsp_q.size() == 0) begin
          check("rsp_unexpected", rsp_valid_o, 0);
        end else begin
          env_rsp = exp_rsp_q.pop_front();
          check("rsp_write", rsp_write_o, env_rsp.write);
          check("rsp_rdata", rsp_rdata_o, env_rsp.rdata);
          check("rsp_err",   rsp_err_o,   env_rsp.err);
        end
      end

      if (psel_o && !penable_o) begin
        if (exp_apb_q.size() == 0) begin
          check("apb_unexpected", psel_o, 0);
        end else begin
          env_apb = exp_apb_q.pop_front();
          check("paddr",  paddr_o,  env_apb.addr);
          check("pwrite", pwrite_o, env_apb.write);
          check("pstrb",  pstrb_o,  env_apb.strb);
          if (env_apb.write) check("pwdata", pwdata_o, env_apb.wdata);
          if (pwrite_o) check("write_while_busy", prev_busy, 0);
        end
      end

      if (psel_o && penable_o) begin
        if (!slv_active) begin
          slv_active = 1'b1;
          slv_cnt    = 0;
          if (plan_q.size() != 0) begin
            slv_plan = plan_q.pop_front();
          end else begin
            check("slave_plan_empty", plan_q.size(), 1);
            slv_plan = '{0, 1'b0};
          end
        end
        slv_cnt++;
        if (slv_cnt > slv_plan.waits) begin
          pready_i  = 1'b1;
          pslverr_i = slv_plan.err;
          prdata_i  = (!pwrite_o && !slv_plan.err) ? rd_slv(paddr_o) : $urandom;
          if (pwrite_o && !slv_plan.err) slv_mem[paddr_o] = merge(rd_slv(paddr_o), pwdata_o, pstrb_o);
        end else begin
          pready_i  = 1'b0;
          pslverr_i = 1'($urandom_range(0, 1));
          prdata_i  = $urandom;
        end
      end else begin
        if (slv_active) begin
          check("access_cycles", slv_cnt, (slv_plan.waits >= TMO) ? TMO : slv_plan.waits + 1);
          slv_active = 1'b0;
        end
        pready_i  = 1'b0;
        pslverr_i = 1'b0;
        prdata_i  = $urandom;
      end

      if (rand_env) busy_i = ($urandom_range(0, 9) < 3);
      prev_busy = busy_i;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_t c;
    plan_t p;
    int   n;

    // Reset state
    #1 rst_i = 1'b1;
    #1;
    check("rst_psel",      psel_o, 0);
    check("rst_penable",   penable_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_cmd_ready", cmd_ready_o, 0);
    check("rst_paddr",     paddr_o, 0);
    check("rst_pstrb",     pstrb_o, 0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    #1 check("ready_after_reset", cmd_ready_o, 1);
    @(negedge clk_i);

    // Minimum-latency write
    rsp_ready_i = 1'b1;
    busy_i      = 1'b0;
    c = '{1'b1, 16'h0004, 32'hA5A5_0001, 4'hF};
    p = '{0, 1'b0};
    model(c, p);
    cmd_valid_i = 1'b1; cmd_write_i = c.write; cmd_addr_i = c.addr;
    cmd_wdata_i = c.wdata; cmd_strb_i = c.strb;
    check("lat_ready", cmd_ready_o, 1);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    check("lat_e0_psel", psel_o, 0);
    @(negedge clk_i);
    check("lat_e1_psel", psel_o, 1);
    check("lat_e1_penable", penable_o, 0);
    @(negedge clk_i);
    check("lat_e2_psel", psel_o, 1);
    check("lat_e2_penable", penable_o, 1);
    @(negedge clk_i);
    check("lat_e3_rsp_valid", rsp_valid_o, 1);
    check("lat_e3_rsp_write", rsp_write_o, 1);
    check("lat_e3_rsp_err", rsp_err_o, 0);
    check("lat_e3_rsp_rdata", rsp_rdata_o, 0);
    drain();

    // Read with two wait states
    send_cmd('{1'b1, 16'h0010, 32'h1234_5678, 4'hF}, '{0, 1'b0});
    send_cmd('{1'b0, 16'h0010, 32'hDEAD_BEEF, 4'hF}, '{2, 1'b0});
    drain();

    // Response backpressure: one held response plus a full FIFO
    rsp_ready_i = 1'b0;
    for (int i = 0; i < 5; i++)
      send_cmd('{1'($urandom_range(0, 1)), AW'(i * 4), $urandom, 4'($urandom_range(0, 15))}, '{0, 1'b0});
    check("bp_cmd_ready_low", cmd_ready_o, 0);
    for (int i = 0; i < 4; i++) begin
      check("bp_no_setup", psel_o, 0);
      check("bp_rsp_held", rsp_valid_o, 1);
      @(negedge clk_i);
    end
    rsp_ready_i = 1'b1;
    send_cmd('{1'b0, 16'h0008, 32'h0, 4'h0}, '{1, 1'b0});
    drain();

    // Busy accelerator holds a write and the read queued behind it
    busy_i = 1'b1;
    send_cmd('{1'b1, 16'h0018, 32'hCAFE_F00D, 4'h5}, '{0, 1'b0});
    send_cmd('{1'b0, 16'h0018, 32'h0, 4'h0}, '{0, 1'b0});
    for (int i = 0; i < 6; i++) begin
      check("busy_no_apb", psel_o, 0);
      @(negedge clk_i);
    end
    busy_i = 1'b0;
    n = 0;
    while (!psel_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    check("busy_first_is_write", pwrite_o, 1);
    drain();

    // Slave that never responds, then a normal transfer
    send_cmd('{1'b0, 16'h0010, 32'h0, 4'h0}, '{1000, 1'b0});
    drain();
    send_cmd('{1'b1, 16'h001C, 32'h0BAD_CAFE, 4'hC}, '{0, 1'b0});
    send_cmd('{1'b0, 16'h001C, 32'h0, 4'h0}, '{0, 1'b0});
    drain();

    // Randomized traffic
    rand_env = 1'b1;
    for (int i = 0; i < 250; i++) begin
      int r;
      c.write = 1'($urandom_range(0, 1));
      c.addr  = AW'($urandom_range(0, 7) * 4);
      c.wdata = $urandom;
      c.strb  = 4'($urandom_range(0, 15));
      r = $urandom_range(0, 19);
      if (r == 0)      p = '{TMO + $urandom_range(0, 4), 1'b0};
      else if (r < 3)  p = '{$urandom_range(0, 3), 1'b1};
      else             p = '{$urandom_range(0, 3), 1'b0};
      send_cmd(c, p);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk_i);
    end
    drain();
    rand_env    = 1'b0;
    rsp_ready_i = 1'b1;
    busy_i      = 1'b0;
    @(negedge clk_i);

    // Reset in the middle of ACCESS
    send_cmd('{1'b0, 16'h0004, 32'h0, 4'h0}, '{5, 1'b0});
    n = 0;
    while (!penable_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    check("rst_reach_access", penable_o, 1);
    #2 rst_i = 1'b1;
    #1;
    check("midrst_psel", psel_o, 0);
    check("midrst_penable", penable_o, 0);
    check("midrst_rsp_valid", rsp_valid_o, 0);
    check("midrst_cmd_ready", cmd_ready_o, 0);
    plan_q.delete();
    exp_rsp_q.delete();
    exp_apb_q.delete();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    #1 check("postrst_cmd_ready", cmd_ready_o, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check("postrst_psel", psel_o, 0);
      check("postrst_rsp_valid", rsp_valid_o, 0);
    end
    send_cmd('{1'b0, 16'h0004, 32'h0, 4'h0}, '{0, 1'b0});
    drain();
    check("plan_left", plan_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
